// File: rtl/flit_demux_1to2.sv
// Packet-aware 1:2 flit demultiplexer.
// The HEAD flit picks the output port, and every flit up to the TAIL follows it through a one-flit register per port.
module flit_demux_1to2 #(
    parameter int DATAW   = 66,
    parameter int VCHW    = 2,
    parameter int DST_BIT = 0,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCHW-1:0]  ivch,
    output logic             iready,
    output logic [DATAW-1:0] odata_0,
    output logic             ovalid_0,
    output logic [VCHW-1:0]  ovch_0,
    input  logic             oready_0,
    output logic [DATAW-1:0] odata_1,
    output logic             ovalid_1,
    output logic [VCHW-1:0]  ovch_1,
    input  logic             oready_1,
    output logic [CNTW-1:0]  pkts_0,
    output logic [CNTW-1:0]  pkts_1,
    output logic             err
);

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_DATA = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_route;

    logic [1:0]  w_type;
    logic        w_tgt;
    logic        w_tgt_free;
    logic        w_iready;
    logic        w_acc;
    logic        w_fwd;
    logic        w_load_0;
    logic        w_load_1;
    logic        w_tail_0;
    logic        w_tail_1;

    assign w_type = idata[DATAW-1 -: 2];
    assign iready = w_iready;

    // The target port is the held route inside a packet, or the HEAD's destination bit when idle.
    always_comb begin
        w_tgt      = (r_state == S_PKT) ? r_route : idata[DST_BIT];
        w_tgt_free = w_tgt ? (~ovalid_1 | oready_1) : (~ovalid_0 | oready_0);
        if (rst) begin
            w_iready = 1'b0;
        end else if (r_state == S_PKT) begin
            w_iready = w_tgt_free;
        end else if (ivalid && (w_type == T_HEAD)) begin
            w_iready = w_tgt_free;
        end else begin
            w_iready = 1'b1;
        end
        w_acc = ivalid & w_iready;
        if (r_state == S_PKT) begin
            w_fwd = w_acc & (w_type != T_NONE);
        end else begin
            w_fwd = w_acc & (w_type == T_HEAD);
        end
        w_load_0 = w_fwd & ~w_tgt;
        w_load_1 = w_fwd & w_tgt;
        w_tail_0 = ovalid_0 & oready_0 & (odata_0[DATAW-1 -: 2] == T_TAIL);
        w_tail_1 = ovalid_1 & oready_1 & (odata_1[DATAW-1 -: 2] == T_TAIL);
    end

    // Route/packet state and the sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_route <= 1'b0;
            err     <= 1'b0;
        end else if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    case (w_type)
                        T_HEAD: begin
                            r_state <= S_PKT;
                            r_route <= idata[DST_BIT];
                        end
                        T_DATA, T_TAIL: err <= 1'b1;
                        default: ;
                    endcase
                end
                S_PKT: begin
                    case (w_type)
                        T_TAIL:  r_state <= S_IDLE;
                        T_HEAD:  err <= 1'b1;
                        default: ;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Port 0 flit buffer: a load may coincide with the drain of the previous flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            odata_0  <= {DATAW{1'b0}};
            ovch_0   <= {VCHW{1'b0}};
            ovalid_0 <= 1'b0;
        end else if (w_load_0) begin
            odata_0  <= idata;
            ovch_0   <= ivch;
            ovalid_0 <= 1'b1;
        end else if (oready_0) begin
            ovalid_0 <= 1'b0;
        end
    end

    // Port 1 flit buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            odata_1  <= {DATAW{1'b0}};
            ovch_1   <= {VCHW{1'b0}};
            ovalid_1 <= 1'b0;
        end else if (w_load_1) begin
            odata_1  <= idata;
            ovch_1   <= ivch;
            ovalid_1 <= 1'b1;
        end else if (oready_1) begin
            ovalid_1 <= 1'b0;
        end
    end

    // Saturating delivered-packet counters, stepped by TAIL handshakes on each port.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkts_0 <= {CNTW{1'b0}};
            pkts_1 <= {CNTW{1'b0}};
        end else begin
            if (w_tail_0 && (pkts_0 != {CNTW{1'b1}})) begin
                pkts_0 <= pkts_0 + {{(CNTW-1){1'b0}}, 1'b1};
            end
            if (w_tail_1 && (pkts_1 != {CNTW{1'b1}})) begin
                pkts_1 <= pkts_1 + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_flit_demux_1to2.sv
// Bench for flit_demux_1to2: directed scenarios then random traffic, checked against a queue-based packet model.
module tb_flit_demux_1to2;

    localparam int DATAW = 66;
    localparam int VCHW  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [DATAW-1:0] idata;
    logic             ivalid;
    logic [VCHW-1:0]  ivch;
    logic             iready;
    logic [DATAW-1:0] odata_0, odata_1;
    logic             ovalid_0, ovalid_1;
    logic [VCHW-1:0]  ovch_0, ovch_1;
    logic             oready_0, oready_1;
    logic [15:0]      pkts_0, pkts_1;
    logic             err;

    logic             s_iready, s_ovalid_0, s_ovalid_1, s_err;
    logic [DATAW-1:0] s_odata_0, s_odata_1;
    logic [VCHW-1:0]  s_ovch_0, s_ovch_1;
    logic [1:0]       s_pkts_0, s_pkts_1;

    always #5 clk = ~clk;

    flit_demux_1to2 #(.DATAW(DATAW), .VCHW(VCHW), .DST_BIT(0), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
        .odata_0(odata_0), .ovalid_0(ovalid_0), .ovch_0(ovch_0), .oready_0(oready_0),
        .odata_1(odata_1), .ovalid_1(ovalid_1), .ovch_1(ovch_1), .oready_1(oready_1),
        .pkts_0(pkts_0), .pkts_1(pkts_1), .err(err)
    );

    flit_demux_1to2 #(.DATAW(DATAW), .VCHW(VCHW), .DST_BIT(0), .CNTW(2)) u_sat (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(s_iready),
        .odata_0(s_odata_0), .ovalid_0(s_ovalid_0), .ovch_0(s_ovch_0), .oready_0(oready_0),
        .odata_1(s_odata_1), .ovalid_1(s_ovalid_1), .ovch_1(s_ovch_1), .oready_1(oready_1),
        .pkts_0(s_pkts_0), .pkts_1(s_pkts_1), .err(s_err)
    );

    typedef struct packed {
        logic [DATAW-1:0] d;
        logic [VCHW-1:0]  c;
    } fl_t;

    // Reference model: what each port should be presenting, and packet-level bookkeeping.
    fl_t q0[$];
    fl_t q1[$];
    bit  m_in_pkt;
    bit  m_route;
    bit  m_err;
    int  m_cnt[2];
    int  seen[2];

    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] mk(input logic [1:0] t, input logic [63:0] pl);
        return {t, pl};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_in_pkt = 1'b0;
        m_route  = 1'b0;
        m_err    = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        seen[0]  = 0;
        seen[1]  = 0;
    endtask

    task automatic push(input bit p, input fl_t f);
        if (p) q1.push_back(f);
        else   q0.push_back(f);
    endtask

    // One clock cycle: drive, compare every output against the model, then advance the model.
    task automatic step(input logic v, input logic [DATAW-1:0] d, input logic [VCHW-1:0] c,
                        input logic r0, input logic r1, input logic rs, output logic acc);
        logic [1:0] typ;
        logic       tgt;
        logic       free0, free1, exp_rdy;
        fl_t        f;
        @(negedge clk);
        ivalid = v; idata = d; ivch = c; oready_0 = r0; oready_1 = r1; rst = rs;
        #1;
        typ   = d[DATAW-1 -: 2];
        free0 = (q0.size() == 0) || r0;
        free1 = (q1.size() == 0) || r1;
        if (rs)             exp_rdy = 1'b0;
        else if (m_in_pkt)  exp_rdy = m_route ? free1 : free0;
        else if (v && typ == 2'b01) begin
            tgt     = d[0];
            exp_rdy = tgt ? free1 : free0;
        end else            exp_rdy = 1'b1;
        chk("iready", 66'(iready), 66'(exp_rdy));
        chk("ovalid_0", 66'(ovalid_0), 66'(q0.size() != 0));
        chk("ovalid_1", 66'(ovalid_1), 66'(q1.size() != 0));
        if (q0.size() != 0) begin
            chk("odata_0", odata_0, q0[0].d);
            chk("ovch_0", 66'(ovch_0), 66'(q0[0].c));
        end
        if (q1.size() != 0) begin
            chk("odata_1", odata_1, q1[0].d);
            chk("ovch_1", 66'(ovch_1), 66'(q1[0].c));
        end
        chk("pkts_0", 66'(pkts_0), 66'(m_cnt[0]));
        chk("pkts_1", 66'(pkts_1), 66'(m_cnt[1]));
        chk("err", 66'(err), 66'(m_err));
        chk("sat_pkts_0", 66'(s_pkts_0), 66'(sat3(m_cnt[0])));
        chk("sat_pkts_1", 66'(s_pkts_1), 66'(sat3(m_cnt[1])));
        acc = v & exp_rdy & ~rs;
        if (rs) begin
            model_clear();
        end else begin
            if (q0.size() != 0 && r0) begin
                f = q0.pop_front();
                seen[0]++;
                if (f.d[DATAW-1 -: 2] == 2'b10 && m_cnt[0] < 65535) m_cnt[0]++;
            end
            if (q1.size() != 0 && r1) begin
                f = q1.pop_front();
                seen[1]++;
                if (f.d[DATAW-1 -: 2] == 2'b10 && m_cnt[1] < 65535) m_cnt[1]++;
            end
            if (acc) begin
                f.d = d;
                f.c = c;
                if (!m_in_pkt) begin
                    if (typ == 2'b01) begin
                        m_route  = d[0];
                        m_in_pkt = 1'b1;
                        push(m_route, f);
                    end else if (typ != 2'b00) begin
                        m_err = 1'b1;
                    end
                end else if (typ != 2'b00) begin
                    push(m_route, f);
                    if (typ == 2'b10) m_in_pkt = 1'b0;
                    if (typ == 2'b01) m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        logic a;
        step(1'b0, 66'd0, 2'd0, 1'b1, 1'b1, 1'b1, a);
        step(1'b0, 66'd0, 2'd0, 1'b1, 1'b1, 1'b1, a);
    endtask

    // Offer a flit with both outputs ready; it must be taken in the very same cycle.
    task automatic send_now(input string tag, input logic [1:0] t, input logic [63:0] pl);
        logic a;
        step(1'b1, mk(t, pl), 2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0, a);
        chk(tag, 66'(a), 66'd1);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) step(1'b0, 66'd0, 2'd0, 1'b1, 1'b1, 1'b0, a);
    endtask

    initial begin
        logic a;
        rst = 1'b1; ivalid = 1'b0; idata = '0; ivch = '0; oready_0 = 1'b1; oready_1 = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);

        // Reset mid-packet with a flit stuck in port0's buffer.
        do_reset();
        step(1'b1, mk(2'b01, 64'h0), 2'd3, 1'b0, 1'b1, 1'b0, a);
        chk("rst_head_acc", 66'(a), 66'd1);
        step(1'b1, mk(2'b11, 64'h55), 2'd1, 1'b0, 1'b1, 1'b0, a);
        do_reset();
        step(1'b0, 66'd0, 2'd0, 1'b1, 1'b1, 1'b0, a);
        #1;
        chk("rst_odata_0", odata_0, 66'd0);
        chk("rst_ovch_0", 66'(ovch_0), 66'd0);
        chk("rst_ovalid_0", 66'(ovalid_0), 66'd0);
        chk("rst_odata_1", odata_1, 66'd0);
        chk("rst_err", 66'(err), 66'd0);
        send_now("rst_next_head", 2'b01, 64'h1);
        send_now("rst_next_tail", 2'b10, rnd64());
        idle(2);

        // Route: HEAD payload 0x09 goes to port1 with 20 DATA and a TAIL.
        do_reset();
        send_now("route_head", 2'b01, 64'h09);
        for (int k = 0; k < 20; k++) send_now("route_data", 2'b11, rnd64());
        send_now("route_tail", 2'b10, rnd64());
        idle(2);
        chk("route_seen1", 66'(seen[1]), 66'd22);
        chk("route_seen0", 66'(seen[0]), 66'd0);
        chk("route_pkts1", 66'(pkts_1), 66'd1);

        // Backpressure on port0 mid-packet.
        do_reset();
        send_now("bp_head", 2'b01, 64'h2);
        send_now("bp_data", 2'b11, rnd64());
        send_now("bp_data", 2'b11, rnd64());
        for (int k = 0; k < 5; k++) begin
            step(1'b1, mk(2'b11, 64'hABCD), 2'd2, 1'b0, 1'b1, 1'b0, a);
            chk("bp_stall", 66'(a), 66'd0);
        end
        for (int k = 0; k < 3; k++) send_now("bp_resume", 2'b11, rnd64());
        send_now("bp_tail", 2'b10, rnd64());
        idle(2);
        chk("bp_seen0", 66'(seen[0]), 66'd7);
        chk("bp_seen1", 66'(seen[1]), 66'd0);

        // Alternation 0,1,0 without bubbles.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            send_now("alt_head", 2'b01, {rnd64() & 64'hFFFF_FFFF_FFFF_FFFE} | 64'(p & 1));
            send_now("alt_data", 2'b11, rnd64());
            send_now("alt_tail", 2'b10, rnd64());
        end
        idle(2);
        chk("alt_pkts0", 66'(pkts_0), 66'd2);
        chk("alt_pkts1", 66'(pkts_1), 66'd1);

        // Protocol errors.
        do_reset();
        send_now("err_data_idle", 2'b11, rnd64());
        idle(1);
        chk("err_idle_flag", 66'(err), 66'd1);
        chk("err_idle_drop", 66'(seen[0] + seen[1]), 66'd0);
        do_reset();
        send_now("err_head", 2'b01, 64'h0);
        send_now("err_head2", 2'b01, 64'h1);
        idle(2);
        chk("err_pkt_flag", 66'(err), 66'd1);
        chk("err_pkt_seen0", 66'(seen[0]), 66'd2);
        chk("err_pkt_seen1", 66'(seen[1]), 66'd0);

        // Saturation: five packets on port0.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_now("sat_head", 2'b01, 64'h4);
            send_now("sat_tail", 2'b10, rnd64());
        end
        idle(2);
        chk("sat_cnt2", 66'(s_pkts_0), 66'd3);
        chk("sat_cnt16", 66'(pkts_0), 66'd5);

        // Random traffic with random backpressure and occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 3) != 0, mk(2'($urandom_range(0, 3)), rnd64()),
                 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, a);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
